// File: rtl/mcs6530_timer_if.sv
// Bus bundle for the MCS6530 interval timer: CPU access strobe, address, data and IRQ.
// The read-data line is do_o because "do" is a reserved word in SystemVerilog.
interface mcs6530_timer_if;
   logic       cs;
   logic       we_n;
   logic [3:0] addr;
   logic [7:0] di;
   logic [7:0] do_o;
   logic       irq_n;

   modport master (output cs, we_n, addr, di, input do_o, irq_n);
   modport slave  (input cs, we_n, addr, di, output do_o, irq_n);
endinterface

// File: rtl/mcs6530_timer.sv
// MCS6530 interval timer: 8-bit count with /1,/8,/64,/1024 prescale and an expiry flag.
// Define MCS6530_TIMER_IRQ_EN to let the flag drive irq_n; otherwise irq_n stays high.
module mcs6530_timer (
   input  logic           phi2,
   input  logic           rst_n,
   mcs6530_timer_if.slave bus
);

`ifdef MCS6530_TIMER_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

   state_t     state_q;
   logic [7:0] count_q;
   logic [7:0] do_q;
   logic [9:0] presc_q;
   logic [9:0] reload_q;
   logic       flag_q;
   logic       irq_en_q;

   logic acc, wr, rd_cnt, rd_flag, irq_en_d;

   function automatic logic [9:0] presc_reload(input logic [1:0] sel);
      case (sel)
         2'b00:   presc_reload = 10'd0;
         2'b01:   presc_reload = 10'd7;
         2'b10:   presc_reload = 10'd63;
         default: presc_reload = 10'd1023;
      endcase
   endfunction

   assign acc      = bus.cs & bus.addr[2];
   assign wr       = acc & ~bus.we_n;
   assign rd_cnt   = acc &  bus.we_n & ~bus.addr[0];
   assign rd_flag  = acc &  bus.we_n &  bus.addr[0];
   assign irq_en_d = bus.addr[3] & IRQ_BUILD;

   always_ff @(posedge phi2) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= 8'h00;
         presc_q  <= 10'd0;
         reload_q <= 10'd0;
         flag_q   <= 1'b0;
         irq_en_q <= 1'b0;
         do_q     <= 8'h00;
      end else begin
         if (rd_cnt)
            do_q <= count_q;
         else if (rd_flag)
            do_q <= {flag_q, 7'b0};

         if (wr) begin
            count_q  <= bus.di;
            reload_q <= presc_reload(bus.addr[1:0]);
            presc_q  <= presc_reload(bus.addr[1:0]);
            irq_en_q <= irq_en_d;
            flag_q   <= 1'b0;
            state_q  <= COUNT;
         end else begin
            if (rd_cnt) begin
               flag_q   <= 1'b0;
               irq_en_q <= irq_en_d;
            end
            // Expiry sets the flag after the read clear so it wins a same-cycle read.
            case (state_q)
               COUNT: begin
                  if (presc_q == 10'd0) begin
                     presc_q <= reload_q;
                     if (count_q != 8'h00) begin
                        count_q <= count_q - 8'h01;
                     end else begin
                        count_q <= 8'hFF;
                        flag_q  <= 1'b1;
                        state_q <= EXPIRED;
                     end
                  end else begin
                     presc_q <= presc_q - 10'd1;
                  end
               end
               EXPIRED: count_q <= count_q - 8'h01;
               default: ;
            endcase
         end
      end
   end

   assign bus.do_o  = do_q;
   assign bus.irq_n = ~(flag_q & irq_en_q);

endmodule

// File: doc/mcs6530_timer.md
MCS6530_TIMER -- requirements
Module: mcs6530_timer

Interface
REQ-001 SHALL have port phi2  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port cs  input  1  qualified timer access strobe, high for exactly one phi2 cycle per bus access.
REQ-004 SHALL have port we_n  input  1  bus direction; 0 = write, 1 = read.
REQ-005 SHALL have port addr  input  4  A3..A0 of the access.
REQ-006 SHALL have port di  input  8  write data.
REQ-007 SHALL have port do  output  8  registered read data.
REQ-008 SHALL have port irq_n  output  1  active-low interrupt request, to be driven onto PB7 open-drain by the top level.

Function
REQ-009 SHALL ignore any cycle in which cs=0 or addr[2]=0, except for internal counting.
REQ-010 SHALL, on a write (cs=1, we_n=0, addr[2]=1), load count<=di, set divisor from addr[1:0] (00=1, 01=8, 10=64, 11=1024), set irq_en<=addr[3], clear flag, set presc<=divisor-1, and enter COUNT.
REQ-011 SHALL implement states IDLE (count held), COUNT (prescaled) and EXPIRED (divide-by-1).
REQ-012 SHALL, in COUNT, generate a tick when presc==0 (reload presc<=divisor-1), else decrement presc; divisor 1 ticks every cycle.
REQ-013 SHALL, on a tick in COUNT, decrement count if nonzero; if count==0, load count<=8'hFF, set flag and enter EXPIRED.
REQ-014 SHALL, in EXPIRED, decrement count every cycle with 8-bit wrap (00->FF), flag held.
REQ-015 SHALL, on a read with addr[0]=0, load do<=count (pre-decrement value), clear flag and set irq_en<=addr[3].
REQ-016 SHALL, on a read with addr[0]=1, load do<={flag,7'b0} and leave flag unchanged.
REQ-017 SHALL hold do at its last value when no read occurs.
REQ-018 SHALL give a write priority over a same-cycle tick or expiry (load wins, flag cleared).
REQ-019 SHALL give an expiry priority over a same-cycle count read (flag ends set; do returns 8'h00).
REQ-020 SHALL drive irq_n = ~(flag & irq_en) from registered state, with no combinational path from inputs.

Reset
REQ-021 SHALL, while rst_n=0 at a phi2 edge, set count=0, presc=0, divisor=1, flag=0, irq_en=0, do=8'h00, state=IDLE, giving irq_n=1.
REQ-022 SHALL abort any count in progress when reset is asserted and remain in IDLE until the next write.

Configuration
REQ-023 SHALL, with MCS6530_TIMER_IRQ_EN defined, drive irq_n per REQ-020.
REQ-024 SHALL, without MCS6530_TIMER_IRQ_EN, tie irq_n to 1 and hold irq_en at 0, while flag, counting and reads remain fully functional.

Verification
REQ-025 SHALL test: write 8'h03 at addr 4'b0100 at edge k -> count reads 02/01/00 at k+1/k+2/k+3; at k+4 count=FF, flag=1, irq_n=1 because irq_en=0.
REQ-026 SHALL test: write 8'h02 at addr 4'b1101 (/8, IRQ enabled) at edge k -> count 01 at k+8, 00 at k+16; at k+24 count=FF and irq_n=0; count then reaches FE at k+25.
REQ-027 SHALL test, after REQ-026 expiry: read addr 4'b0101 -> do=8'h80 and irq_n stays 0; then read addr 4'b1100 -> flag=0 and irq_n=1 on the next cycle.
REQ-028 SHALL test: write 8'h01 at addr 4'b0111 (/1024) at edge k -> count=00 at k+1024 and expiry (FF, flag=1) at k+2048.
REQ-029 SHALL test: write 8'h10 at addr 4'b0100 in the same cycle as an EXPIRED-state decrement -> count=10 next cycle, flag=0, state COUNT.
REQ-030 SHALL test: assert rst_n=0 mid-count -> all outputs at reset values and count frozen; with the macro undefined, REQ-026 stimulus leaves irq_n=1 throughout while flag reads 8'h80.
